// File: rtl/fir_mac_seq_if.sv
// -----------------------------------------------------------------------------
// fir_mac_seq_if
// Handshake bundle for fir_mac_seq.
//   Input side : x, coe (operands), in_valid / in_ready (beat handshake),
//                clear (synchronous frame abort)
//   Output side: y (completed sum), ovf (overflow flag of that frame),
//                y_valid / y_ready (result handshake)
// Modports:
//   master - the producer/consumer around the filter (drives operands,
//            clear and y_ready)
//   slave  - the filter itself
// DATA_W and ACC_W must match the parameters of the attached fir_mac_seq.
// -----------------------------------------------------------------------------
interface fir_mac_seq_if #(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 32
);
   logic [DATA_W-1:0] x;
   logic [DATA_W-1:0] coe;
   logic              in_valid;
   logic              in_ready;
   logic              clear;
   logic [ACC_W-1:0]  y;
   logic              y_valid;
   logic              y_ready;
   logic              ovf;

   modport master (
      output x, coe, in_valid, clear, y_ready,
      input  in_ready, y, y_valid, ovf
   );

   modport slave (
      input  x, coe, in_valid, clear, y_ready,
      output in_ready, y, y_valid, ovf
   );
endinterface

// File: rtl/fir_mac_seq.sv
// -----------------------------------------------------------------------------
// fir_mac_seq
// Sequential FIR multiply-accumulate. Each accepted beat adds x*coe (full
// 2*DATA_W precision, signed or unsigned) into an ACC_W accumulator; after
// NUM_TAPS accepted beats the sum is presented on y with a frame-local
// overflow flag.
// Ports:
//   clk     - clock, all state changes on the rising edge
//   reset   - asynchronous, active-low reset
//   io_bus  - fir_mac_seq_if.slave: x, coe, in_valid, in_ready, clear,
//             y, y_valid, y_ready, ovf
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_valid/x/coe form one channel (beat accepted when
// in_valid & in_ready); y_valid/y/ovf form the other (result consumed when
// y_valid & y_ready). y and ovf are held stable while y_valid=1 and
// y_ready=0. in_ready only drops for the frame-completing beat while an
// unconsumed result is still waiting on y, and it never depends on in_valid.
// -----------------------------------------------------------------------------
module fir_mac_seq #(
   parameter int DATA_W    = 32,
   parameter int NUM_TAPS  = 11,
   parameter int ACC_W     = 32,
   parameter bit SIGNED_EN = 1'b0,
   parameter bit SAT_EN    = 1'b0
) (
   input logic           clk,
   input logic           reset,
   fir_mac_seq_if.slave  io_bus
);

   localparam int CNT_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
   localparam int PROD_W = 2 * DATA_W;
   // Two guard bits above the wider of product/accumulator make the exact
   // sum of an in-range accumulator and any product representable.
   localparam int EXT_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 2;

   localparam logic [CNT_W-1:0]        LAST_TAP = CNT_W'(NUM_TAPS - 1);
   localparam logic signed [EXT_W-1:0] ONE_EXT  = 1;
   // Representable range of the accumulator in the selected number system.
   localparam logic signed [EXT_W-1:0] LIM_HI   = (SIGNED_EN != 1'b0) ?
                                                  (ONE_EXT <<< (ACC_W - 1)) - ONE_EXT :
                                                  (ONE_EXT <<< ACC_W) - ONE_EXT;
   localparam logic signed [EXT_W-1:0] LIM_LO   = (SIGNED_EN != 1'b0) ?
                                                  -(ONE_EXT <<< (ACC_W - 1)) :
                                                  '0;

   logic [ACC_W-1:0]        r_acc;
   logic [CNT_W-1:0]        r_tap;
   logic                    r_sticky;
   logic [ACC_W-1:0]        r_y;
   logic                    r_y_valid;
   logic                    r_ovf;

   logic                    w_last;
   logic                    w_in_ready;
   logic                    w_take;
   logic [PROD_W-1:0]       w_x_ext;
   logic [PROD_W-1:0]       w_coe_ext;
   logic [PROD_W-1:0]       w_prod_raw;
   logic signed [EXT_W-1:0] w_prod;
   logic signed [EXT_W-1:0] w_acc_ext;
   logic signed [EXT_W-1:0] w_sum;
   logic                    w_beat_ovf;
   logic [ACC_W-1:0]        w_acc_next;

   assign w_last     = (r_tap == LAST_TAP);
   // Only the frame-completing beat can stall: it needs the output slot.
   assign w_in_ready = !(w_last && r_y_valid && !io_bus.y_ready);
   // clear discards any beat offered in the same cycle.
   assign w_take     = io_bus.in_valid && w_in_ready && !io_bus.clear;

   // Operands are extended to PROD_W before multiplying, so the low PROD_W
   // bits of the product are the exact signed/unsigned product.
   generate
      if (SIGNED_EN != 1'b0) begin : g_signed
         assign w_x_ext   = {{DATA_W{io_bus.x[DATA_W-1]}}, io_bus.x};
         assign w_coe_ext = {{DATA_W{io_bus.coe[DATA_W-1]}}, io_bus.coe};
         assign w_prod    = {{(EXT_W-PROD_W){w_prod_raw[PROD_W-1]}}, w_prod_raw};
         assign w_acc_ext = {{(EXT_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
      end else begin : g_unsigned
         assign w_x_ext   = {{DATA_W{1'b0}}, io_bus.x};
         assign w_coe_ext = {{DATA_W{1'b0}}, io_bus.coe};
         assign w_prod    = {{(EXT_W-PROD_W){1'b0}}, w_prod_raw};
         assign w_acc_ext = {{(EXT_W-ACC_W){1'b0}}, r_acc};
      end
   endgenerate

   assign w_prod_raw = w_x_ext * w_coe_ext;
   assign w_sum      = w_acc_ext + w_prod;
   assign w_beat_ovf = (w_prod > LIM_HI) || (w_prod < LIM_LO) ||
                       (w_sum  > LIM_HI) || (w_sum  < LIM_LO);

   always_comb begin
      w_acc_next = w_sum[ACC_W-1:0];
      if (SAT_EN != 1'b0) begin
         if (w_sum > LIM_HI) begin
            w_acc_next = LIM_HI[ACC_W-1:0];
         end else if (w_sum < LIM_LO) begin
            w_acc_next = LIM_LO[ACC_W-1:0];
         end
      end
   end

   // Frame state: accumulator, tap counter, sticky overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc    <= '0;
         r_tap    <= '0;
         r_sticky <= 1'b0;
      end else if (io_bus.clear) begin
         r_acc    <= '0;
         r_tap    <= '0;
         r_sticky <= 1'b0;
      end else if (w_take) begin
         if (w_last) begin
            r_acc    <= '0;
            r_tap    <= '0;
            r_sticky <= 1'b0;
         end else begin
            r_acc    <= w_acc_next;
            r_tap    <= r_tap + CNT_W'(1);
            r_sticky <= r_sticky | w_beat_ovf;
         end
      end
   end

   // Output slot. A completing frame reloads y/ovf even when the previous
   // result is consumed on the same edge, so y_valid stays high then.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_y       <= '0;
         r_y_valid <= 1'b0;
         r_ovf     <= 1'b0;
      end else if (w_take && w_last) begin
         r_y       <= w_acc_next;
         r_y_valid <= 1'b1;
         r_ovf     <= r_sticky | w_beat_ovf;
      end else if (io_bus.y_ready) begin
         r_y_valid <= 1'b0;
      end
   end

   assign io_bus.in_ready = w_in_ready;
   assign io_bus.y        = r_y;
   assign io_bus.y_valid  = r_y_valid;
   assign io_bus.ovf      = r_ovf;

endmodule

// File: doc/fir_mac_seq.md
FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

Interface
REQ-001 Parameter DATA_W, default 32: width of the x and coe operands.
REQ-002 Parameter NUM_TAPS, default 11: number of accepted products summed per output sample; legal range 1..1024.
REQ-003 Parameter ACC_W, default 32: width of the accumulator and y; legal range DATA_W..2*DATA_W+10.
REQ-004 Parameter SIGNED_EN, default 0: 0 treats operands and products as unsigned; 1 treats them as two's complement.
REQ-005 Parameter SAT_EN, default 0: 0 gives wrap-around modulo 2^ACC_W; 1 clamps to the ACC_W range, signed or unsigned per SIGNED_EN.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 x  input  DATA_W  sample operand.
REQ-009 coe  input  DATA_W  coefficient operand.
REQ-010 in_valid  input  1  x/coe pair offered this cycle.
REQ-011 in_ready  output  1  block accepts the pair this cycle.
REQ-012 clear  input  1  synchronous frame abort.
REQ-013 y  output  ACC_W  completed filter sum.
REQ-014 y_valid  output  1  y holds an unconsumed result.
REQ-015 y_ready  input  1  downstream consumes y this cycle.
REQ-016 ovf  output  1  overflow or saturation occurred in the frame now presented on y; qualified by y_valid.

Function
REQ-017 A beat is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-018 in_ready shall be 1 except when tap_cnt equals NUM_TAPS-1 and y_valid=1 and y_ready=0; only the frame-completing beat stalls.
REQ-019 The product x*coe shall be full precision (2*DATA_W bits), sign- or zero-extended per SIGNED_EN, and added to the accumulator each accepted beat.
REQ-020 Accumulation result:
- SAT_EN=0: truncated to ACC_W bits.
- SAT_EN=1: clamped to the ACC_W maximum or minimum.
REQ-021 A frame-local sticky flag shall set on any beat whose exact sum or product does not fit in ACC_W.
REQ-022 tap_cnt runs 0..NUM_TAPS-1 and increments on each accepted beat.
REQ-023 On the accepted beat with tap_cnt=NUM_TAPS-1, the block shall, on the same edge:
- load the final sum, including that beat's product, into y;
- set y_valid=1;
- copy the sticky flag into ovf;
- reset the accumulator, the sticky flag and tap_cnt to 0.
REQ-024 Latency: y_valid rises one cycle after the edge that accepts the last tap.
REQ-025 y_valid shall clear on an edge with y_ready=1 unless a new frame completes on that same edge, in which case y and ovf shall reload and y_valid shall stay 1.
REQ-026 y and ovf shall remain stable while y_valid=1 and y_ready=0.
REQ-027 clear=1 shall zero the accumulator, tap_cnt and the sticky flag, and shall discard any beat offered that cycle.
REQ-028 clear shall not affect y, y_valid or ovf; a pending result survives clear.
REQ-029 With NUM_TAPS=1, every accepted beat shall complete a frame.
REQ-030 in_valid=0 shall hold all state; idle gaps between beats within a frame are legal.

Reset
REQ-031 While reset=0, the following shall be 0 asynchronously: the accumulator, tap_cnt, sticky flag, y, y_valid and ovf.
REQ-032 in_ready shall read 1 during and immediately after reset.
REQ-033 A reset mid-frame shall discard the partial sum; the first beat after release shall be tap 0.

Verification
REQ-034 Defaults, 11 beats x=1..11, coe=2, y_ready=1 -> one y_valid pulse, y=132, ovf=0, one cycle after the 11th beat.
REQ-035 Defaults, y_ready=0, 22 beats x=1, coe=1 -> first y=11 held; in_ready=0 on the 22nd beat until y_ready=1; the next result is y=11.
REQ-036 SIGNED_EN=1, SAT_EN=1, ACC_W=32, 11 beats x=32'h7FFFFFFF, coe=2 -> y=32'h7FFFFFFF, ovf=1.
REQ-037 SAT_EN=0, same stimulus as REQ-036 -> y equals the sum modulo 2^32, ovf=1.
REQ-038 5 beats x=3, coe=3, then clear=1 for one cycle, then 11 beats x=1, coe=1 -> y=11; the prior partial sum of 45 is lost.
REQ-039 reset=0 asserted after 7 beats, then released, then 11 beats x=2, coe=2 -> y=44; no y_valid before the 11th post-reset beat.
